postprocess_pack_writer: RTL and testbench

- Receiving end of the post-process rescale pipeline: accepts tagged int8 pairs (iter, data0, data1) and packs PAIRS_PER_WORD pairs into one wide output-buffer word.
- Issues byte-masked write requests to the feature-map output buffer with valid/ready backpressure, and returns ready to the upstream stage so it can drive the rescale pipeline's en.

---
 rtl/postprocess_pkg.sv | 22 ++
 rtl/postprocess_out_reg.sv | 63 ++++++
 rtl/postprocess_pack_writer.sv | 165 ++++++++++++++++
 tb/tb_postprocess_pack_writer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postprocess_pkg.sv
// Shared definitions for the post-process rescale pipeline: field widths,
// pack-writer state encoding and the iter lane/word split helpers.
package postprocess_pkg;

    localparam int ITER_W = 9;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FLUSH
    } pp_state_e;

    function automatic logic [ITER_W-1:0] lane_of(input logic [ITER_W-1:0] iter, input int lg);
        return iter & ((ITER_W'(1) << lg) - ITER_W'(1));
    endfunction

    function automatic logic [ITER_W-1:0] widx_of(input logic [ITER_W-1:0] iter, input int lg);
        return iter >> lg;
    endfunction

endpackage

// File: rtl/postprocess_out_reg.sv
// One-entry valid/ready output register holding a write request.
module postprocess_out_reg #(
    parameter int ADDR_W = 9,
    parameter int DW     = 64,
    parameter int MW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DW-1:0]     ld_data,
    input  logic [MW-1:0]     ld_mask,
    output logic              can_load,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic [MW-1:0]     wr_mask
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [MW-1:0]     mask_q, mask_d;

    // A new word may enter only when the slot is free or draining this cycle.
    assign can_load = !valid_q || wr_ready;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (ld) begin
            valid_d = 1'b1;
            addr_d  = ld_addr;
            data_d  = ld_data;
            mask_d  = ld_mask;
        end else if (wr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign wr_valid = valid_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign wr_mask  = mask_q;

endmodule

// File: rtl/postprocess_pack_writer.sv
// Packs tagged int8 pairs into wide output-buffer words and issues
// byte-masked writes with valid/ready backpressure.
module postprocess_pack_writer
    import postprocess_pkg::*;
#(
    parameter int PAIRS_PER_WORD = 4,
    parameter int ADDR_W         = 9,
    parameter int BASE_ADDR      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ITER_W-1:0]           iter_in,
    input  logic [DATA_W-1:0]           data_in0,
    input  logic [DATA_W-1:0]           data_in1,
    input  logic                        flush,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [16*PAIRS_PER_WORD-1:0] wr_data,
    output logic [2*PAIRS_PER_WORD-1:0] wr_mask,
    output logic                        done
);

    localparam int P  = PAIRS_PER_WORD;
    localparam int LG = $clog2(P);
    localparam int DW = 16 * P;
    localparam int MW = 2 * P;

    pp_state_e         state_q, state_d;
    logic [DW-1:0]     part_data_q, part_data_d;
    logic [MW-1:0]     part_mask_q, part_mask_d;
    logic [ITER_W-1:0] widx_q, widx_d;

    logic [LG-1:0]     lane;
    logic [ITER_W-1:0] widx;
    logic [ADDR_W-1:0] in_addr, part_addr;
    logic [DW-1:0]     ins_data, lane_dmask, merged_data;
    logic [MW-1:0]     ins_mask, merged_mask;
    logic              is_last, blocked, widx_chg, accept, can_load;

    logic              ld;
    logic [ADDR_W-1:0] ld_addr;
    logic [DW-1:0]     ld_data;
    logic [MW-1:0]     ld_mask;

    assign lane      = LG'(lane_of(iter_in, LG));
    assign widx      = widx_of(iter_in, LG);
    assign in_addr   = ADDR_W'(BASE_ADDR + int'(widx));
    assign part_addr = ADDR_W'(BASE_ADDR + int'(widx_q));
    assign is_last   = (lane == LG'(P - 1));

    assign ins_data    = DW'({data_in1, data_in0}) << {lane, 4'b0};
    assign lane_dmask  = DW'(16'hFFFF) << {lane, 4'b0};
    assign ins_mask    = MW'(2'b11) << {lane, 1'b0};
    assign merged_data = (part_data_q & ~lane_dmask) | ins_data;
    assign merged_mask = part_mask_q | ins_mask;

    // A word-index change stalls the new pair one cycle while the partial leaves.
    assign blocked  = wr_valid && !wr_ready;
    assign widx_chg = (state_q == FILL) && (widx != widx_q);
    assign in_ready = !rst && !blocked && (state_q != FLUSH) && !widx_chg;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        part_data_d = part_data_q;
        part_mask_d = part_mask_q;
        widx_d      = widx_q;
        ld          = 1'b0;
        ld_addr     = part_addr;
        ld_data     = part_data_q;
        ld_mask     = part_mask_q;
        done        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (is_last) begin
                        ld      = 1'b1;
                        ld_addr = in_addr;
                        ld_data = ins_data;
                        ld_mask = ins_mask;
                    end else begin
                        part_data_d = ins_data;
                        part_mask_d = ins_mask;
                        widx_d      = widx;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                if (widx_chg) begin
                    if (can_load) begin
                        ld          = 1'b1;
                        part_data_d = '0;
                        part_mask_d = '0;
                        state_d     = EMPTY;
                    end
                end else if (accept) begin
                    if (is_last) begin
                        ld          = 1'b1;
                        ld_data     = merged_data;
                        ld_mask     = merged_mask;
                        part_data_d = '0;
                        part_mask_d = '0;
                        state_d     = EMPTY;
                    end else begin
                        part_data_d = merged_data;
                        part_mask_d = merged_mask;
                    end
                end
            end
            FLUSH: begin
                if (part_mask_q != '0) begin
                    if (can_load) begin
                        ld          = 1'b1;
                        part_data_d = '0;
                        part_mask_d = '0;
                    end
                end else if (!wr_valid) begin
                    done    = 1'b1;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins the state; a pair accepted this cycle is already folded in.
        if (flush) state_d = FLUSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            part_data_q <= '0;
            part_mask_q <= '0;
            widx_q      <= '0;
        end else begin
            state_q     <= state_d;
            part_data_q <= part_data_d;
            part_mask_q <= part_mask_d;
            widx_q      <= widx_d;
        end
    end

    postprocess_out_reg #(
        .ADDR_W(ADDR_W),
        .DW    (DW),
        .MW    (MW)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_mask (ld_mask),
        .can_load(can_load),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_mask (wr_mask)
    );

endmodule

// File: tb/tb_postprocess_pack_writer.sv
// Scoreboard bench for postprocess_pack_writer: directed pair streams with
// hand-computed expected writes, checked by an independent monitor.
module tb_postprocess_pack_writer;

    localparam int AW = 9;
    localparam int DW = 64;
    localparam int MW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, flush, wr_valid, wr_ready, done;
    logic [8:0]    iter_in;
    logic [7:0]    data_in0, data_in1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;

    logic          in_valid2, in_ready2, flush2, wr_valid2, wr_ready2, done2;
    logic [8:0]    iter_in2;
    logic [7:0]    data2_0, data2_1;
    logic [AW-1:0] wr_addr2;
    logic [DW-1:0] wr_data2;
    logic [MW-1:0] wr_mask2;

    wr_t           exp_q[$];
    wr_t           e_m;
    int            checks = 0, errors = 0, cyc = 0;
    int            last_wr_cyc = -1, done_cyc = -1, flush_cyc = -1;
    int            stall_cnt = 0, n_writes = 0;
    logic          prev_blk = 1'b0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [MW-1:0] pm;

    localparam logic [DW-1:0] WORD0 = 64'hFD03_FE02_FF01_0000;
    localparam logic [DW-1:0] WORD1 = 64'hF907_FA06_FB05_FC04;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    postprocess_pack_writer #(.PAIRS_PER_WORD(4), .ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .iter_in(iter_in),
        .data_in0(data_in0), .data_in1(data_in1), .flush(flush), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .done(done)
    );

    postprocess_pack_writer #(.PAIRS_PER_WORD(4), .ADDR_W(AW), .BASE_ADDR(510)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .iter_in(iter_in2),
        .data_in0(data2_0), .data_in1(data2_1), .flush(flush2), .wr_valid(wr_valid2),
        .wr_ready(wr_ready2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_mask(wr_mask2), .done(done2)
    );

    // Monitor: pops the scoreboard on every write transfer and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_blk = 1'b0;
        end else begin
            if (prev_blk) begin
                checks++;
                if (!wr_valid || wr_addr != pa || wr_data != pd || wr_mask != pm) begin
                    errors++;
                    $display("FAIL hold: got v=%0b a=%0h d=%h m=%h, need v=1 a=%0h d=%h m=%h",
                             wr_valid, wr_addr, wr_data, wr_mask, pa, pd, pm);
                end
            end
            if (in_valid && !in_ready) stall_cnt++;
            if (done) done_cyc = cyc;
            if (wr_valid && wr_ready) begin
                n_writes++;
                last_wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected a=%0h d=%h m=%h", wr_addr, wr_data, wr_mask);
                end else begin
                    e_m = exp_q.pop_front();
                    if (wr_addr != e_m.addr || wr_data != e_m.data || wr_mask != e_m.mask) begin
                        errors++;
                        $display("FAIL write: got a=%0h d=%h m=%h, need a=%0h d=%h m=%h",
                                 wr_addr, wr_data, wr_mask, e_m.addr, e_m.data, e_m.mask);
                    end
                end
            end
            prev_blk = wr_valid && !wr_ready;
            pa = wr_addr;
            pd = wr_data;
            pm = wr_mask;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.mask = m;
        exp_q.push_back(w);
    endtask

    task automatic send(input int i);
        logic acc = 1'b0;
        int   n = 0;
        in_valid = 1'b1;
        iter_in  = 9'(i);
        data_in0 = 8'(i);
        data_in1 = 8'(-i);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL send: iter %0d not accepted, need accept within 50 cycles", i);
        end
    endtask

    task automatic do_flush();
        flush     = 1'b1;
        flush_cyc = cyc;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cyc < 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done: no pulse, need pulse within 40 cycles");
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d writes missing, need 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0;
        rst = 1'b1; in_valid = 1'b0; iter_in = '0; data_in0 = '0; data_in1 = '0;
        flush = 1'b0; wr_ready = 1'b0;
        in_valid2 = 1'b0; iter_in2 = '0; data2_0 = '0; data2_1 = '0; flush2 = 1'b0; wr_ready2 = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_mask", wr_mask, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Consecutive stream: two full words, no bubbles.
        stall_cnt = 0;
        push(9'd0, WORD0, 8'hFF);
        push(9'd1, WORD1, 8'hFF);
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(i);
        chk("stream_cycles", 64'(cyc - c0), 8);
        wait_drain();
        chk("stream_no_stall", 64'(stall_cnt), 0);

        // Word-index jump: partial leaves, one stall cycle, then lane 0 of addr 3.
        stall_cnt = 0;
        push(9'd1, 64'h0000_0000_FB05_FC04, 8'h0F);
        send(4); send(5); send(12);
        chk("jump_stall", 64'(stall_cnt), 1);
        push(9'd3, 64'h0000_0000_0000_F40C, 8'h03);
        done_cyc = -1;
        do_flush();
        wait_done();
        wait_drain();

        // Backpressure: wr_ready low for 5 cycles while streaming.
        stall_cnt = 0;
        wr_ready  = 1'b0;
        push(9'd0, WORD0, 8'hFF);
        push(9'd1, WORD1, 8'hFF);
        fork
            for (int i = 0; i < 8; i++) send(i);
            begin
                repeat (5) @(posedge clk);
                #1;
                wr_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_stalled", 64'(stall_cnt > 0), 1);

        // Flush of a partial word, then flush with nothing pending.
        push(9'd2, 64'h0000_0000_F709_F808, 8'h0F);
        send(8); send(9);
        done_cyc = -1;
        do_flush();
        wait_done();
        chk("flush_done_after_wr", 64'(done_cyc), 64'(last_wr_cyc + 1));
        wait_drain();
        w0 = n_writes;
        done_cyc = -1;
        do_flush();
        wait_done();
        chk("flush_empty_done", 64'(done_cyc), 64'(flush_cyc + 1));
        repeat (3) @(posedge clk);
        #1;
        chk("flush_empty_nowr", 64'(n_writes), 64'(w0));

        // Reset with a blocked write, then with a partial pending.
        wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i);
        @(negedge clk);
        chk("pre_rst_blocked", wr_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wr_valid", wr_valid, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_mask", wr_mask, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(4); send(5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_ready = 1'b1;
        w0 = n_writes;
        push(9'd0, WORD0, 8'hFF);
        for (int i = 0; i < 4; i++) send(i);
        wait_drain();
        chk("post_rst_one_write", 64'(n_writes - w0), 1);

        // Address wrap: BASE_ADDR 510 + word 2 -> 0.
        begin
            logic got = 1'b0;
            int   n = 0;
            in_valid2 = 1'b1; iter_in2 = 9'd8; data2_0 = 8'h11; data2_1 = 8'h22;
            while (!got && n < 20) begin
                @(negedge clk); got = in_ready2; @(posedge clk); #1; n++;
            end
            in_valid2 = 1'b0;
            flush2 = 1'b1;
            @(posedge clk); #1;
            flush2 = 1'b0;
            got = 1'b0; n = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                if (wr_valid2) begin
                    got = 1'b1;
                    chk("wrap_addr", wr_addr2, 0);
                    chk("wrap_data", wr_data2, 64'h2211);
                    chk("wrap_mask", wr_mask2, 8'h03);
                end
                n++;
            end
            if (!got) begin
                errors++;
                $display("FAIL wrap_write: no write, need one within 20 cycles");
            end
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
